fifo_rd_packer: RTL and testbench

//  Downstream read-side stage of the FIFO. Pops DATA_WIDTH words from the FIFO read port,

---
 rtl/fifo_rd_packer.sv | 91 +++++++++
 tb/tb_fifo_rd_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops narrow words, packs RATIO of them into one wide beat
// on a valid/ready stream, with flush support for partial beats.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          flush,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [RATIO*DATA_WIDTH-1:0]   m_data,
  output logic [$clog2(RATIO+1)-1:0]    m_count
);

  localparam int unsigned CW     = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);
  localparam logic [CW:0] FULL_W = (CW + 1)'(RATIO);
  localparam bit REG_RD          = (RD_LATENCY != 0);

  logic [RATIO-1:0][DATA_WIDTH-1:0] lanes, view_lanes;
  logic [CW-1:0] cnt, view_cnt;
  logic          inflight, flush_pending;
  logic          out_free, merge_in, flush_ok, acc_xfer, room, pop, arrive;

  always_comb begin
    out_free = !m_valid || m_ready;
    // With registered reads, the word landing this cycle is folded into the beat
    // being moved so a full beat leaves without a one-cycle bubble.
    merge_in   = REG_RD && inflight;
    view_lanes = lanes;
    view_cnt   = cnt;
    if (merge_in) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (cnt == CW'(i)) view_lanes[i] = fifo_data;
      end
      view_cnt = cnt + CW'(1);
    end
    flush_ok   = flush_pending && (cnt != '0) && !inflight;
    acc_xfer   = out_free && ((view_cnt == FULL) || flush_ok);
    room       = ({1'b0, cnt} + {{CW{1'b0}}, inflight}) < FULL_W;
    fifo_rd_en = rst_n && !fifo_empty && !flush_pending && (room || acc_xfer);
    pop        = fifo_rd_en && !fifo_empty;
    arrive     = REG_RD ? inflight : pop;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes         <= '0;
      cnt           <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_count       <= '0;
    end else begin
      inflight <= REG_RD && pop;

      if (acc_xfer) begin
        m_data  <= view_lanes;
        m_count <= view_cnt;
        m_valid <= 1'b1;
        lanes   <= '0;
        cnt     <= '0;
        if (arrive && !merge_in) begin
          lanes[0] <= fifo_data;
          cnt      <= CW'(1);
        end
      end else begin
        if (m_valid && m_ready) m_valid <= 1'b0;
        if (arrive) begin
          for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt == CW'(i)) lanes[i] <= fifo_data;
          end
          cnt <= cnt + CW'(1);
        end
      end

      if (flush_pending) begin
        if (acc_xfer || ((cnt == '0) && !inflight)) flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: one registered-read and one combinational-read
// instance run the same stimulus, each fed by its own FIFO read-port model.
module tb_fifo_rd_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic m_ready = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int wp = 0, rp1 = 0, rp0 = 0, cyc = 0;
  int passed = 0, total = 0;

  logic        rd_en1, rd_en0, empty1, empty0, mv1, mv0;
  logic [7:0]  fd1, fd0;
  logic [31:0] md1, md0;
  logic [2:0]  mc1, mc0;

  assign empty1 = (rp1 == wp);
  assign empty0 = (rp0 == wp);
  assign fd0    = mem[rp0[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en1 && (rp1 != wp)) begin
      fd1 <= mem[rp1[7:0]];
      rp1 <= rp1 + 1;
    end
    if (rd_en0 && (rp0 != wp)) rp0 <= rp0 + 1;
  end

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4), .RD_LATENCY(1)) dut1 (
    .rd_clk(clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
    .fifo_data(fd1), .flush(flush), .m_valid(mv1), .m_ready(m_ready),
    .m_data(md1), .m_count(mc1)
  );

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4), .RD_LATENCY(0)) dut0 (
    .rd_clk(clk), .rst_n(rst_n), .fifo_empty(empty0), .fifo_rd_en(rd_en0),
    .fifo_data(fd0), .flush(flush), .m_valid(mv0), .m_ready(m_ready),
    .m_data(md0), .m_count(mc0)
  );

  logic [34:0] got1[$], got0[$];
  int t1[$];
  int bad_rd = 0;
  logic chk_rd = 1'b0;

  always @(negedge clk) begin
    if (mv1 && m_ready) begin
      got1.push_back({mc1, md1});
      t1.push_back(cyc);
    end
    if (mv0 && m_ready) got0.push_back({mc0, md0});
    if (chk_rd && ((!empty1 && !rd_en1) || (!empty0 && !rd_en0))) bad_rd++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wp[7:0]] = w;
    wp++;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k = 0;
    while ((got1.size() < n || got0.size() < n) && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 64'(k < 400), 64'(1));
  endtask

  task automatic chk_beat(input string tag, input logic [34:0] exp);
    logic [34:0] o1, o0;
    o1 = 'x;
    o0 = 'x;
    if (got1.size() > 0) o1 = got1.pop_front();
    if (got0.size() > 0) o0 = got0.pop_front();
    chk({tag, "_lat1"}, 64'(o1), 64'(exp));
    chk({tag, "_lat0"}, 64'(o0), 64'(exp));
  endtask

  task automatic chk_idle(input string tag);
    repeat (5) tick();
    chk(tag, 64'(got1.size() + got0.size()), 64'(0));
  endtask

  function automatic logic [34:0] beat4(input logic [7:0] w0, input logic [7:0] w1,
                                        input logic [7:0] w2, input logic [7:0] w3);
    return {3'd4, w3, w2, w1, w0};
  endfunction

  function automatic logic [7:0] w4(input int i);
    return 8'(i * 5 + 3);
  endfunction

  function automatic logic [7:0] w6(input int i);
    return 8'(8'h80 + i * 7);
  endfunction

  initial begin
    int k, ok;

    // Reset state; FIFO already non-empty so the forced-low read enable is visible
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (2) tick();
    chk("rst_valid1", 64'(mv1), 64'(0));
    chk("rst_valid0", 64'(mv0), 64'(0));
    chk("rst_count1", 64'(mc1), 64'(0));
    chk("rst_data1", 64'(md1), 64'(0));
    chk("rst_rd_en1", 64'(rd_en1), 64'(0));
    chk("rst_rd_en0", 64'(rd_en0), 64'(0));

    // 1: four words, one full beat
    rst_n = 1'b1;
    #1;
    chk("t1_rd_en_first", 64'(rd_en1), 64'(1));
    k = 0;
    while ((rp1 < 4 || rp0 < 4) && k < 50) begin tick(); k++; end
    chk("t1_pop_wait", 64'(k < 50), 64'(1));
    chk("t1_rd_en1_after4", 64'(rd_en1), 64'(0));
    chk("t1_rd_en0_after4", 64'(rd_en0), 64'(0));
    wait_beats(1, "t1_wait");
    chk_beat("t1_beat", {3'd4, 32'h44332211});
    chk_idle("t1_no_extra");

    // 2: backpressure with 16 words
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    repeat (30) tick();
    chk("t2_pops1", 64'(rp1), 64'(12));
    chk("t2_pops0", 64'(rp0), 64'(12));
    chk("t2_rd_en1_held", 64'(rd_en1), 64'(0));
    chk("t2_rd_en0_held", 64'(rd_en0), 64'(0));
    chk("t2_valid1", 64'(mv1), 64'(1));
    chk("t2_data1", 64'(md1), 64'(32'h04030201));
    chk("t2_data0", 64'(md0), 64'(32'h04030201));
    repeat (3) tick();
    chk("t2_data1_stable", 64'(md1), 64'(32'h04030201));
    chk("t2_count1_stable", 64'(mc1), 64'(4));
    m_ready = 1'b1;
    wait_beats(4, "t2_wait");
    chk_beat("t2_beat0", {3'd4, 32'h04030201});
    chk_beat("t2_beat1", {3'd4, 32'h08070605});
    chk_beat("t2_beat2", {3'd4, 32'h0C0B0A09});
    chk_beat("t2_beat3", {3'd4, 32'h100F0E0D});
    chk_idle("t2_no_extra");

    // 3: partial flush, empty flush, flush with full accumulator
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_beats(1, "t3_wait");
    chk_beat("t3_partial", {3'd3, 32'h00332211});
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(8'hAA);
    #1;
    chk("t3_pending_rd_en1", 64'(rd_en1), 64'(0));
    chk("t3_pending_rd_en0", 64'(rd_en0), 64'(0));
    chk("t3_empty_flush_valid", 64'(mv1), 64'(0));
    tick();
    chk("t3_cleared_rd_en1", 64'(rd_en1), 64'(1));
    chk("t3_cleared_rd_en0", 64'(rd_en0), 64'(1));
    chk("t3_no_beat", 64'(mv1 | mv0), 64'(0));
    push(8'hBB); push(8'hCC); push(8'hDD);
    wait_beats(1, "t3_wait2");
    chk_beat("t3_after_flush", {3'd4, 32'hDDCCBBAA});
    repeat (3) tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(8'h30 + i));
    repeat (20) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    chk("t3_full_held", 64'(mv1), 64'(1));
    m_ready = 1'b1;
    wait_beats(2, "t3_wait3");
    chk_beat("t3_full0", {3'd4, 32'h34333231});
    chk_beat("t3_full1", {3'd4, 32'h38373635});
    chk_idle("t3_no_extra");

    // 4: 64-word stream
    t1.delete();
    chk_rd = 1'b1;
    for (int i = 0; i < 64; i++) push(w4(i));
    wait_beats(16, "t4_wait");
    repeat (3) tick();
    chk_rd = 1'b0;
    chk("t4_rd_en_gaps", 64'(bad_rd), 64'(0));
    ok = 0;
    for (int j = 1; j < 16; j++) if (t1.size() > j && t1[j] - t1[j-1] == 4) ok++;
    chk("t4_interval", 64'(ok), 64'(15));
    for (int j = 0; j < 16; j++)
      chk_beat($sformatf("t4_beat%0d", j),
               beat4(w4(4*j), w4(4*j+1), w4(4*j+2), w4(4*j+3)));
    chk_idle("t4_no_extra");

    // 5: reset mid-operation with a held beat and two buffered words
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(8'h70 + i));
    repeat (20) tick();
    chk("t5_pre_valid", 64'(mv1), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid1", 64'(mv1), 64'(0));
    chk("t5_async_valid0", 64'(mv0), 64'(0));
    chk("t5_async_count1", 64'(mc1), 64'(0));
    chk("t5_async_data1", 64'(md1), 64'(0));
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    wait_beats(1, "t5_wait");
    chk_beat("t5_clean", {3'd4, 32'h54535251});
    chk_idle("t5_no_extra");

    // 6: random downstream throttling
    for (int i = 0; i < 40; i++) push(w6(i));
    k = 0;
    while ((got1.size() < 10 || got0.size() < 10) && k < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    m_ready = 1'b1;
    chk("t6_wait", 64'(k < 2000), 64'(1));
    for (int j = 0; j < 10; j++)
      chk_beat($sformatf("t6_beat%0d", j),
               beat4(w6(4*j), w6(4*j+1), w6(4*j+2), w6(4*j+3)));
    chk_idle("t6_no_extra");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
